// File: rtl/inst_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_ctrl_if
// Description : Control, ROM and IF/ID signal bundle for the fetch controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_fetch_ctrl_if;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        halted;

  // The fetch controller owns the ROM address and the IF/ID register.
  modport slave (
    input  freeze,
    input  branch_taken,
    input  branch_addr,
    input  rom_inst,
    output rom_addr,
    output inst_out,
    output pc_out,
    output valid_out,
    output halted
  );

  modport master (
    output freeze,
    output branch_taken,
    output branch_addr,
    output rom_inst,
    input  rom_addr,
    input  inst_out,
    input  pc_out,
    input  valid_out,
    input  halted
  );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_ctrl
// Description : PC sequencing, redirect, stall and self-jump halt for fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter bit          HALT_ON_SELF_JMP = 1'b1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  inst_fetch_ctrl_if.slave  bus
);

  localparam logic [31:0] c_SELF_JMP   = 32'hA800_FFFF;
  localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t      state_q,  state_d;
  logic [31:0] pc_q,     pc_d;
  logic [31:0] inst_q,   inst_d;
  logic [31:0] pcout_q,  pcout_d;
  logic        valid_q,  valid_d;

  logic [31:0] w_pc_plus4;
  logic        w_self_jmp;

  // Natural 32-bit overflow gives the required modulo-2^32 wrap.
  assign w_pc_plus4 = pc_q + 32'd4;
  assign w_self_jmp = HALT_ON_SELF_JMP && (bus.rom_inst == c_SELF_JMP);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    pcout_d = pcout_q;
    valid_d = valid_q;
    case (state_q)
      S_RUN: begin
        if (bus.branch_taken) begin
          pc_d    = bus.branch_addr & c_ALIGN_MASK;
          inst_d  = 32'h0;
          pcout_d = 32'h0;
          valid_d = 1'b0;
        end else if (!bus.freeze) begin
          pc_d    = w_pc_plus4;
          inst_d  = bus.rom_inst;
          pcout_d = w_pc_plus4;
          valid_d = 1'b1;
          if (w_self_jmp) begin
            state_d = S_HALT;
          end
        end
      end
      S_HALT: begin
        // Bubble the IF/ID register once; reloading zeros afterwards is a hold.
        inst_d  = 32'h0;
        pcout_d = 32'h0;
        valid_d = 1'b0;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      pcout_q <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pcout_q <= pcout_d;
      valid_q <= valid_d;
    end
  end

  assign bus.rom_addr  = pc_q;
  assign bus.inst_out  = inst_q;
  assign bus.pc_out    = pcout_q;
  assign bus.valid_out = valid_q;
  assign bus.halted    = (state_q == S_HALT);

  a_halt_holds_pc : assert property (
    @(posedge clk) disable iff (rst)
    (state_q == S_HALT) |=> (pc_q == $past(pc_q))
  );

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_ctrl
// Description : Scoreboard bench for inst_fetch_ctrl with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_ctrl;

  typedef struct {
    string       name;
    bit          which;
    logic [31:0] inst;
    logic [31:0] pcout;
    logic [31:0] pc;
    logic        valid;
    logic        halted;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] rom [0:1023];
  exp_t        sb [$];
  int          total;
  int          bad;

  inst_fetch_ctrl_if bus0 ();
  inst_fetch_ctrl_if bus1 ();

  assign bus0.freeze       = freeze;
  assign bus0.branch_taken = branch_taken;
  assign bus0.branch_addr  = branch_addr;
  assign bus0.rom_inst     = rom[bus0.rom_addr[11:2]];
  assign bus1.freeze       = freeze;
  assign bus1.branch_taken = branch_taken;
  assign bus1.branch_addr  = branch_addr;
  assign bus1.rom_inst     = rom[bus1.rom_addr[11:2]];

  inst_fetch_ctrl #(
    .RESET_PC         (32'h0000_0000),
    .HALT_ON_SELF_JMP (1'b1)
  ) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  inst_fetch_ctrl #(
    .RESET_PC         (32'hFFFF_FFFC),
    .HALT_ON_SELF_JMP (1'b0)
  ) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: each edge with a queued expectation is checked 1 time unit later.
  always begin
    exp_t        e;
    logic [31:0] a_inst, a_pcout, a_pc;
    logic        a_valid, a_halted;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.which) begin
        a_inst = bus1.inst_out; a_pcout = bus1.pc_out; a_pc = bus1.rom_addr;
        a_valid = bus1.valid_out; a_halted = bus1.halted;
      end else begin
        a_inst = bus0.inst_out; a_pcout = bus0.pc_out; a_pc = bus0.rom_addr;
        a_valid = bus0.valid_out; a_halted = bus0.halted;
      end
      total++;
      if (a_inst !== e.inst || a_pcout !== e.pcout || a_pc !== e.pc ||
          a_valid !== e.valid || a_halted !== e.halted) begin
        bad++;
        $display("FAIL %s dut%0d: got inst=%h pc_out=%h rom_addr=%h valid=%b halted=%b, want inst=%h pc_out=%h rom_addr=%h valid=%b halted=%b",
                 e.name, e.which, a_inst, a_pcout, a_pc, a_valid, a_halted,
                 e.inst, e.pcout, e.pc, e.valid, e.halted);
      end
    end
  end

  task automatic step(input string nm, input bit which,
                      input logic r, input logic br, input logic fr,
                      input logic [31:0] ba,
                      input logic [31:0] ei, input logic [31:0] ep,
                      input logic [31:0] epc, input logic ev, input logic eh);
    exp_t e;
    rst          = r;
    branch_taken = br;
    freeze       = fr;
    branch_addr  = ba;
    e.name = nm; e.which = which; e.inst = ei; e.pcout = ep; e.pc = epc;
    e.valid = ev; e.halted = eh;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 1024; i++) rom[i] = 32'h0000_0013;
    rom[0]    = 32'h1111_0000;
    rom[1]    = 32'h2222_1111;
    rom[2]    = 32'h3333_2222;
    rom[3]    = 32'h4444_3333;
    rom[4]    = 32'h5555_4444;
    rom[5]    = 32'hA800_FFFF;
    rom[6]    = 32'h7777_6666;
    rom[16]   = 32'hCAFE_0010;
    rom[17]   = 32'hCAFE_0011;
    rom[1023] = 32'hA800_FFFF;

    // Sequential fetch with a 3-cycle freeze after word 1, then branch vs freeze.
    step("reset",       0, 1, 0, 0, 32'h0,  32'h0,         32'h0,  32'h0,  0, 0);
    step("fetch_w0",    0, 0, 0, 0, 32'h0,  32'h1111_0000, 32'd4,  32'd4,  1, 0);
    step("fetch_w1",    0, 0, 0, 0, 32'h0,  32'h2222_1111, 32'd8,  32'd8,  1, 0);
    step("freeze_1",    0, 0, 0, 1, 32'h0,  32'h2222_1111, 32'd8,  32'd8,  1, 0);
    step("freeze_2",    0, 0, 0, 1, 32'h0,  32'h2222_1111, 32'd8,  32'd8,  1, 0);
    step("freeze_3",    0, 0, 0, 1, 32'h0,  32'h2222_1111, 32'd8,  32'd8,  1, 0);
    step("resume_w2",   0, 0, 0, 0, 32'h0,  32'h3333_2222, 32'd12, 32'd12, 1, 0);
    step("fetch_w3",    0, 0, 0, 0, 32'h0,  32'h4444_3333, 32'd16, 32'd16, 1, 0);
    step("fetch_w4",    0, 0, 0, 0, 32'h0,  32'h5555_4444, 32'd20, 32'd20, 1, 0);
    step("branch_win",  0, 0, 1, 1, 32'h42, 32'h0,         32'h0,  32'h40, 0, 0);
    step("branch_tgt",  0, 0, 0, 0, 32'h99, 32'hCAFE_0010, 32'h44, 32'h44, 1, 0);

    // Run into the self-jump at word 5 and verify HALT ignores everything but rst.
    step("reset2",      0, 1, 0, 0, 32'h0,  32'h0,         32'h0,  32'h0,  0, 0);
    step("h_w0",        0, 0, 0, 0, 32'h0,  32'h1111_0000, 32'd4,  32'd4,  1, 0);
    step("h_w1",        0, 0, 0, 0, 32'h0,  32'h2222_1111, 32'd8,  32'd8,  1, 0);
    step("h_w2",        0, 0, 0, 0, 32'h0,  32'h3333_2222, 32'd12, 32'd12, 1, 0);
    step("h_w3",        0, 0, 0, 0, 32'h0,  32'h4444_3333, 32'd16, 32'd16, 1, 0);
    step("h_w4",        0, 0, 0, 0, 32'h0,  32'h5555_4444, 32'd20, 32'd20, 1, 0);
    step("halt_enter",  0, 0, 0, 0, 32'h0,  32'hA800_FFFF, 32'd24, 32'd24, 1, 1);
    step("halt_bubble", 0, 0, 1, 0, 32'h100,32'h0,         32'h0,  32'd24, 0, 1);
    step("halt_brfz",   0, 0, 1, 1, 32'h200,32'h0,         32'h0,  32'd24, 0, 1);
    step("halt_idle",   0, 0, 0, 0, 32'h0,  32'h0,         32'h0,  32'd24, 0, 1);
    step("halt_reset",  0, 1, 1, 1, 32'h300,32'h0,         32'h0,  32'h0,  0, 0);
    step("post_rst_w0", 0, 0, 0, 0, 32'h0,  32'h1111_0000, 32'd4,  32'd4,  1, 0);

    // Reset in the middle of a freeze and of a redirect.
    step("frz_hold",    0, 0, 0, 1, 32'h0,  32'h1111_0000, 32'd4,  32'd4,  1, 0);
    step("frz_reset",   0, 1, 0, 1, 32'h0,  32'h0,         32'h0,  32'h0,  0, 0);
    step("frz_rst_w0",  0, 0, 0, 0, 32'h0,  32'h1111_0000, 32'd4,  32'd4,  1, 0);
    step("br_reset",    0, 1, 1, 0, 32'h80, 32'h0,         32'h0,  32'h0,  0, 0);
    step("br_rst_w0",   0, 0, 0, 0, 32'h0,  32'h1111_0000, 32'd4,  32'd4,  1, 0);

    // Second instance: PC wrap from 0xFFFFFFFC and self-jump treated as ordinary.
    step("wrap_reset",  1, 1, 0, 0, 32'h0,  32'h0,         32'h0,  32'hFFFF_FFFC, 0, 0);
    step("wrap_edge",   1, 0, 0, 0, 32'h0,  32'hA800_FFFF, 32'h0,  32'h0,  1, 0);
    step("nohalt_w0",   1, 0, 0, 0, 32'h0,  32'h1111_0000, 32'd4,  32'd4,  1, 0);
    step("nohalt_w1",   1, 0, 0, 0, 32'h0,  32'h2222_1111, 32'd8,  32'd8,  1, 0);

    @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_fetch_ctrl.md
INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address loaded into PC on reset.
REQ-002 SHALL have parameter HALT_ON_SELF_JMP, default 1; 1 enables halt detection on the JMP -1 encoding 32'hA800_FFFF.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 freeze  in  1  hazard stall request from the decode/hazard logic.
REQ-007 branch_taken  in  1  redirect request from the execute stage.
REQ-008 branch_addr  in  32  redirect target byte address.
REQ-009 rom_addr  out  32  instruction ROM byte address; ROM returns word rom_addr[11:2].
REQ-010 rom_inst  in  32  combinational ROM data for rom_addr.
REQ-011 inst_out  out  32  IF/ID instruction register.
REQ-012 pc_out  out  32  IF/ID register holding fetch PC + 4.
REQ-013 valid_out  out  1  IF/ID contents are a real fetched instruction.
REQ-014 halted  out  1  fetch has stopped on self-jump.

Function
REQ-015 SHALL hold a 32-bit PC register; rom_addr SHALL equal PC combinationally, with zero added latency.
REQ-016 SHALL implement two states: RUN and HALT; the state register is internal, and halted is 1 exactly in HALT.
REQ-017 In RUN with branch_taken=1, SHALL load PC with {branch_addr[31:2],2'b00}.
  - On the same edge, SHALL load inst_out=0 (NOP), pc_out=0 and valid_out=0.
  - branch_taken SHALL win over freeze.
REQ-018 In RUN with branch_taken=0 and freeze=1, SHALL hold PC, inst_out, pc_out and valid_out unchanged.
REQ-019 In RUN with neither asserted, SHALL load inst_out=rom_inst, pc_out=PC+4, valid_out=1, and PC=PC+4.
REQ-020 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000) without error indication.
REQ-021 If HALT_ON_SELF_JMP=1 and REQ-019 captures rom_inst==32'hA800_FFFF, SHALL transition to HALT on that edge.
  - The JMP word itself is still registered with valid_out=1.
REQ-022 In the first HALT cycle edge, SHALL load inst_out=0, pc_out=0 and valid_out=0; thereafter SHALL hold all outputs.
REQ-023 In HALT, SHALL hold PC and ignore freeze and branch_taken; only rst exits HALT.
REQ-024 If HALT_ON_SELF_JMP=0, the 32'hA800_FFFF encoding SHALL be treated as an ordinary instruction.
REQ-025 A freeze held for any number of cycles SHALL cause no instruction to be lost or duplicated.
  - A fetch resumes at the held PC on the first non-frozen edge.
REQ-026 branch_addr SHALL be sampled only on edges where branch_taken=1 and state is RUN.

Reset
REQ-027 rst=1 at an edge SHALL set PC=RESET_PC, inst_out=0, pc_out=0, valid_out=0, state=RUN and halted=0.
  - rst SHALL take priority over branch_taken, freeze and HALT.
REQ-028 Reset mid-freeze or mid-redirect SHALL discard the pending request; the first post-reset fetch SHALL be from RESET_PC.
REQ-029 Outputs before the first reset edge are undefined; the bench SHALL NOT check them.

Verification
REQ-030 Sequential fetch: rst 1 cycle, ROM words 0..3 = A,B,C,D.
  - Edges 1..4 give inst_out=A,B,C,D and pc_out=4,8,12,16, with valid_out=1.
REQ-031 Freeze: assert freeze 3 cycles after fetching word 1.
  - inst_out stays word1 and rom_addr stays 8; after release, the next edge gives word2 and pc_out=12.
REQ-032 Branch vs freeze: at PC=20, drive branch_taken=1, freeze=1, branch_addr=32'h0000_0042.
  - Next edge: PC=32'h40, inst_out=0, valid_out=0; following edge: inst_out=ROM[16], pc_out=32'h44.
REQ-033 Halt: place 32'hA800_FFFF at word 5.
  - Edge fetching it: inst_out=32'hA800_FFFF, halted=1; next edge: valid_out=0, inst_out=0.
  - PC stays 24 under branch_taken=1; rst returns to RUN at RESET_PC.
REQ-034 Wrap: RESET_PC=32'hFFFF_FFFC; after one edge, PC=0 and pc_out=0.
REQ-035 Reset during HALT with freeze=1 and branch_taken=1: next edge gives PC=RESET_PC, halted=0, valid_out=0.
